ex_alu_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single shared ALU_top instance in the EX stage. It accepts operations from two requesters over a valid/ready handshake, picks one per round-robin and issues it to the ALU with a one-cycle dat_ready pulse. It waits for ALU_ready, or for a timeout, and returns the result and flags on a shared response bus tagged with the requester id. Port 0 serves the main pipeline EX path; port 1 serves the branch/address-compute path.

---
 rtl/ex_alu_arbiter.sv | 138 +++++++++++++
 tb/tb_ex_alu_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_alu_arbiter.sv
`timescale 1ns/1ps
// Two-requester round-robin arbiter and sequencer for the shared EX-stage ALU.
// Latency: accept at E0, ALU start pulse E0-E1, response the cycle after the first WAIT-state alu_ready (or timeout).
// Backpressure: reqN_ready is combinational, only in IDLE with arb_hold low, one requester at a time; one op in flight.
module ex_alu_arbiter #(
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic        soc_clk,
  input  logic        EX_reset_n,
  input  logic        arb_hold,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_dat1,
  input  logic [31:0] req0_dat2,
  input  logic [4:0]  req0_instr,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_dat1,
  input  logic [31:0] req1_dat2,
  input  logic [4:0]  req1_instr,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic        rsp_timeout,
  output logic        busy,
  output logic        alu_dat_ready,
  output logic [31:0] alu_dat1,
  output logic [31:0] alu_dat2,
  output logic [4:0]  alu_instr,
  input  logic        alu_ready,
  input  logic        alu_overflow,
  input  logic        alu_zero,
  input  logic        alu_con_met,
  input  logic        alu_err,
  input  logic [31:0] alu_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // Timer value on the last WAIT sample before the op is abandoned
  localparam logic [3:0] TMO_LAST = 4'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic       last_grant;
  logic       grant_id;
  logic [3:0] timer;
  logic       grant0;
  logic       grant1;

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
  // Gated by reset so no ready leaks out while the block is held in reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (EX_reset_n && state == IDLE && !arb_hold) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Sequencer: accept, pulse the ALU start, wait for ready or timeout, then respond
  always_ff @(posedge soc_clk or negedge EX_reset_n) begin
    if (!EX_reset_n) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      grant_id      <= 1'b0;
      timer         <= 4'd0;
      busy          <= 1'b0;
      alu_dat_ready <= 1'b0;
      alu_dat1      <= 32'd0;
      alu_dat2      <= 32'd0;
      alu_instr     <= 5'd0;
      rsp_valid     <= 1'b0;
      rsp_id        <= 1'b0;
      rsp_result    <= 32'd0;
      rsp_flags     <= 4'd0;
      rsp_timeout   <= 1'b0;
    end else begin
      alu_dat_ready <= 1'b0;
      rsp_valid     <= 1'b0;
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            grant_id      <= grant1;
            alu_dat1      <= grant1 ? req1_dat1 : req0_dat1;
            alu_dat2      <= grant1 ? req1_dat2 : req0_dat2;
            alu_instr     <= grant1 ? req1_instr : req0_instr;
            alu_dat_ready <= 1'b1;
            busy          <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          // alu_ready is deliberately not looked at while the start pulse is out
          timer <= 4'd0;
          state <= WAIT;
        end
        WAIT: begin
          if (alu_ready) begin
            rsp_result  <= alu_out;
            rsp_flags   <= {alu_err, alu_con_met, alu_zero, alu_overflow};
            rsp_timeout <= 1'b0;
            rsp_id      <= grant_id;
            rsp_valid   <= 1'b1;
            last_grant  <= grant_id;
            state       <= DONE;
          end else if (timer == TMO_LAST) begin
            rsp_result  <= 32'd0;
            rsp_flags   <= 4'b1000;
            rsp_timeout <= 1'b1;
            rsp_id      <= grant_id;
            rsp_valid   <= 1'b1;
            last_grant  <= grant_id;
            state       <= DONE;
          end else begin
            timer <= timer + 4'd1;
          end
        end
        DONE: begin
          // Payload registers keep their value; only the valid pulse ends here
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_alu_arbiter.sv
`timescale 1ns/1ps
// Bench for ex_alu_arbiter: vector table, hand sequences for contention/hold/reset,
// and randomized ops checked against a transaction-level round-robin model.
module tb_ex_alu_arbiter;
  localparam int T = 8;

  logic        soc_clk = 1'b0;
  logic        EX_reset_n;
  logic        arb_hold;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_dat1, req0_dat2, req1_dat1, req1_dat2;
  logic [4:0]  req0_instr, req1_instr;
  logic        rsp_valid, rsp_id, rsp_timeout, busy, alu_dat_ready;
  logic [31:0] rsp_result, alu_dat1, alu_dat2, alu_out;
  logic [3:0]  rsp_flags;
  logic [4:0]  alu_instr;
  logic        alu_ready, alu_overflow, alu_zero, alu_con_met, alu_err;

  always #5 soc_clk = ~soc_clk;

  ex_alu_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .soc_clk(soc_clk), .EX_reset_n(EX_reset_n), .arb_hold(arb_hold),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_dat1(req0_dat1),
    .req0_dat2(req0_dat2), .req0_instr(req0_instr),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_dat1(req1_dat1),
    .req1_dat2(req1_dat2), .req1_instr(req1_instr),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout), .busy(busy),
    .alu_dat_ready(alu_dat_ready), .alu_dat1(alu_dat1), .alu_dat2(alu_dat2),
    .alu_instr(alu_instr), .alu_ready(alu_ready), .alu_overflow(alu_overflow),
    .alu_zero(alu_zero), .alu_con_met(alu_con_met), .alu_err(alu_err),
    .alu_out(alu_out)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit model_last = 1'b1;   // requester served most recently (reset: 1)

  typedef struct {
    bit          v0, v1;
    logic [31:0] a0, b0, a1, b1;
    logic [4:0]  i0, i1;
    int          d;        // WAIT samples without alu_ready before it rises
    bit          stray;    // alu_ready high during IDLE/ISSUE
    logic [31:0] aout;
    logic [3:0]  aflags;   // {err, con_met, zero, overflow} from the ALU
    bit          exp_id;
    logic [31:0] exp_res;
    logic [3:0]  exp_fl;
    bit          exp_to;
    int          exp_k;    // response edge index relative to accept edge E0
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic bit pick(input bit v0, input bit v1, input bit last);
    if (v0 && v1) return !last;
    return v1;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_r0"}, 32'(req0_ready), 32'd0);
    check({tag, "_r1"}, 32'(req1_ready), 32'd0);
    check({tag, "_rspv"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rspid"}, 32'(rsp_id), 32'd0);
    check({tag, "_res"}, rsp_result, 32'd0);
    check({tag, "_fl"}, 32'(rsp_flags), 32'd0);
    check({tag, "_to"}, 32'(rsp_timeout), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_dr"}, 32'(alu_dat_ready), 32'd0);
    check({tag, "_d1"}, alu_dat1, 32'd0);
    check({tag, "_d2"}, alu_dat2, 32'd0);
    check({tag, "_ins"}, 32'(alu_instr), 32'd0);
  endtask

  // One complete op; caller must be away from a clock edge with the DUT idle.
  task automatic run_op(input bit v0, input bit v1,
                        input logic [31:0] a0, input logic [31:0] b0,
                        input logic [31:0] a1, input logic [31:0] b1,
                        input logic [4:0] i0, input logic [4:0] i1,
                        input int d, input bit stray,
                        input logic [31:0] aout, input logic [3:0] aflags,
                        input bit exp_id, input logic [31:0] exp_res,
                        input logic [3:0] exp_fl, input bit exp_to, input int exp_k);
    logic [31:0] e1, e2;
    logic [4:0]  ei;
    e1 = exp_id ? a1 : a0;
    e2 = exp_id ? b1 : b0;
    ei = exp_id ? i1 : i0;
    req0_dat1 = a0; req0_dat2 = b0; req0_instr = i0;
    req1_dat1 = a1; req1_dat2 = b1; req1_instr = i1;
    req0_valid = v0; req1_valid = v1;
    alu_ready = stray; alu_out = aout;
    {alu_err, alu_con_met, alu_zero, alu_overflow} = aflags;
    #1;
    check("grant_ready0", 32'(req0_ready), 32'(v0 && !exp_id));
    check("grant_ready1", 32'(req1_ready), 32'(v1 && exp_id));
    @(posedge soc_clk); #1;                       // E0: accepted
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_dat1 = ~a0; req1_dat1 = ~a1; req0_dat2 = ~b0; req1_dat2 = ~b1;
    check("issue_pulse", 32'(alu_dat_ready), 32'd1);
    check("issue_dat1", alu_dat1, e1);
    check("issue_dat2", alu_dat2, e2);
    check("issue_instr", 32'(alu_instr), 32'(ei));
    check("issue_busy", 32'(busy), 32'd1);
    check("issue_noready", 32'(req0_ready | req1_ready), 32'd0);
    @(posedge soc_clk); #1;                       // E1: into WAIT
    alu_ready = (d == 0);
    for (int k = 2; k <= exp_k; k++) begin
      check("wait_pulse_low", 32'(alu_dat_ready), 32'd0);
      check("wait_no_rsp", 32'(rsp_valid), 32'd0);
      check("wait_dat1_stable", alu_dat1, e1);
      @(posedge soc_clk); #1;                     // Ek
      alu_ready = ((k - 1) == d);
    end
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_id", 32'(rsp_id), 32'(exp_id));
    check("rsp_result", rsp_result, exp_res);
    check("rsp_flags", 32'(rsp_flags), 32'(exp_fl));
    check("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
    check("done_noready", 32'(req0_ready | req1_ready), 32'd0);
    @(posedge soc_clk); #1;                       // back in IDLE
    alu_ready = 1'b0;
    check("post_rsp_low", 32'(rsp_valid), 32'd0);
    check("post_rsp_hold", rsp_result, exp_res);
    check("post_busy", 32'(busy), 32'd0);
    model_last = exp_id;
  endtask

  task automatic rand_op(input bit v0, input bit v1);
    logic [31:0] a0, b0, a1, b1, aout;
    logic [4:0]  i0, i1;
    logic [3:0]  fl;
    int d, k;
    bit stray, id, to;
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom; aout = $urandom;
    i0 = 5'($urandom); i1 = 5'($urandom); fl = 4'($urandom);
    d = int'($urandom_range(0, T + 2));
    stray = 1'($urandom);
    id = pick(v0, v1, model_last);
    to = (d >= T);
    k = to ? T + 1 : d + 2;
    run_op(v0, v1, a0, b0, a1, b1, i0, i1, d, stray, aout, fl,
           id, to ? 32'd0 : aout, to ? 4'b1000 : fl, to, k);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit gq[$];
    bit exp_next, gid, seen;
    int grants, rsps, cyc, last_cyc;

    vecs[0] = '{1'b1, 1'b0, 32'd5, 32'd7, 32'h11, 32'h22, 5'd1, 5'd2, 0, 1'b0,
                32'd12, 4'b0000, 1'b0, 32'd12, 4'b0000, 1'b0, 2};
    vecs[1] = '{1'b1, 1'b1, 32'hA0, 32'hB0, 32'hA1, 32'hB1, 5'd3, 5'd4, 3, 1'b1,
                32'hDEADBEEF, 4'b0101, 1'b1, 32'hDEADBEEF, 4'b0101, 1'b0, 5};
    vecs[2] = '{1'b1, 1'b1, 32'd100, 32'd200, 32'd300, 32'd400, 5'd5, 5'd6, 8, 1'b0,
                32'h1234, 4'b0110, 1'b0, 32'd0, 4'b1000, 1'b1, 9};
    vecs[3] = '{1'b0, 1'b1, 32'd1, 32'd2, 32'hFFFF0000, 32'h0000FFFF, 5'd7, 5'd31, 7, 1'b1,
                32'hFFFFFFFF, 4'b1111, 1'b1, 32'hFFFFFFFF, 4'b1111, 1'b0, 9};
    vecs[4] = '{1'b1, 1'b0, 32'h7FFFFFFF, 32'd1, 32'd9, 32'd9, 5'd8, 5'd9, 1, 1'b1,
                32'h80000000, 4'b0001, 1'b0, 32'h80000000, 4'b0001, 1'b0, 3};
    vecs[5] = '{1'b1, 1'b1, 32'h10, 32'h20, 32'h30, 32'h40, 5'd10, 5'd11, 2, 1'b0,
                32'd0, 4'b0010, 1'b1, 32'd0, 4'b0010, 1'b0, 4};
    vecs[6] = '{1'b1, 1'b1, 32'h55, 32'h66, 32'h77, 32'h88, 5'd12, 5'd13, 9, 1'b0,
                32'hCAFE, 4'b0011, 1'b0, 32'd0, 4'b1000, 1'b1, 9};

    // Reset state with requests and alu_ready active
    EX_reset_n = 1'b0; arb_hold = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_dat1 = 32'h1; req0_dat2 = 32'h2; req0_instr = 5'd1;
    req1_dat1 = 32'h3; req1_dat2 = 32'h4; req1_instr = 5'd2;
    alu_ready = 1'b1; alu_out = 32'hFFFF;
    {alu_err, alu_con_met, alu_zero, alu_overflow} = 4'b1111;
    @(posedge soc_clk); #1;
    check_all_zero("reset");
    req0_valid = 1'b0; req1_valid = 1'b0; alu_ready = 1'b0;
    @(negedge soc_clk); EX_reset_n = 1'b1;
    @(posedge soc_clk); #1;

    // Vector table
    for (int i = 0; i < 7; i++)
      run_op(vecs[i].v0, vecs[i].v1, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1,
             vecs[i].i0, vecs[i].i1, vecs[i].d, vecs[i].stray, vecs[i].aout, vecs[i].aflags,
             vecs[i].exp_id, vecs[i].exp_res, vecs[i].exp_fl, vecs[i].exp_to, vecs[i].exp_k);

    // Contention: both valid continuously, ALU always ready
    exp_next = pick(1'b1, 1'b1, model_last);
    req0_valid = 1'b1; req1_valid = 1'b1; alu_ready = 1'b1;
    grants = 0; rsps = 0; cyc = 0; last_cyc = 0;
    while ((grants < 4 || rsps < 4) && cyc < 60) begin
      @(negedge soc_clk); cyc++;
      check("cont_single_ready", 32'(req0_ready & req1_ready), 32'd0);
      check("cont_ready_busy", 32'((req0_ready | req1_ready) & busy), 32'd0);
      if (rsp_valid) begin
        if (gq.size() == 0) check("cont_rsp_unexpected", 32'd1, 32'd0);
        else check("cont_rsp_id", 32'(rsp_id), 32'(gq.pop_front()));
        rsps++;
      end
      if (req0_ready || req1_ready) begin
        gid = req1_ready;
        check("cont_grant_order", 32'(gid), 32'(exp_next));
        exp_next = !exp_next;
        gq.push_back(gid);
        grants++;
        if (grants > 1) check("cont_spacing", 32'(cyc - last_cyc), 32'd4);
        last_cyc = cyc;
        model_last = gid;
        if (grants == 4) begin
          @(posedge soc_clk); #1;
          req0_valid = 1'b0; req1_valid = 1'b0;
        end
      end
    end
    check("cont_grants", 32'(grants), 32'd4);
    check("cont_rsps", 32'(rsps), 32'd4);
    @(posedge soc_clk); #1;
    alu_ready = 1'b0;
    check("cont_idle", 32'(busy), 32'd0);

    // arb_hold blocks a pending request; accepted on the first edge after release
    arb_hold = 1'b1; req1_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge soc_clk);
      check("hold_ready1", 32'(req1_ready), 32'd0);
      check("hold_busy", 32'(busy), 32'd0);
    end
    @(posedge soc_clk); #1;
    arb_hold = 1'b0;
    rand_op(1'b0, 1'b1);

    // Randomized ops against the model
    for (int n = 0; n < 25; n++) begin
      logic [1:0] v;
      v = 2'($urandom_range(1, 3));
      rand_op(v[0], v[1]);
    end

    // Reset mid-WAIT: serve requester 0 first so the tie after reset is meaningful
    rand_op(1'b1, 1'b0);
    req0_valid = 1'b1; req0_dat1 = 32'hA5A5A5A5; req0_dat2 = 32'h5A5A5A5A; req0_instr = 5'd9;
    @(posedge soc_clk); #1;
    req0_valid = 1'b0;
    @(posedge soc_clk); #1;
    @(posedge soc_clk); #1;
    check("rst_pre_busy", 32'(busy), 32'd1);
    alu_ready = 1'b1;
    #2 EX_reset_n = 1'b0;
    #1 check_all_zero("rst_wait");
    @(posedge soc_clk); @(posedge soc_clk);
    @(negedge soc_clk); EX_reset_n = 1'b1;
    model_last = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge soc_clk);
      if (rsp_valid || busy) seen = 1'b1;
    end
    check("rst_no_rsp", 32'(seen), 32'd0);
    alu_ready = 1'b0;
    @(posedge soc_clk); #1;
    rand_op(1'b1, 1'b1);   // model picks requester 0 after reset

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
